branch_resolve_unit: RTL

- EX-side counterpart of the gshare fetch predictor.
- Records each fetch-time prediction in an in-flight queue and pops it when the instruction resolves in EX.
- Compares the predicted next-PC with the actual next-PC, drives the predictor update interface, and on a mismatch issues a redirect plus a pipeline flush.
- Sits between the EX stage and the predictor/fetch unit.

---
 rtl/branch_resolve_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-side partner of the gshare fetch predictor. Every prediction made at
//   fetch is recorded in a small in-flight queue as {pc, predNext}. When the
//   instruction resolves in EX, the oldest entry is popped and its predicted
//   next-PC is compared with the real one. The unit then drives the
//   predictor update port, and on a mismatch it issues a redirect and a flush.
//
// Parameters
//   DEPTH        in-flight queue entries (power of 2, >= 2)
//   FLUSH_CYCLES cycles fetch is held off after a redirect (>= 1)
//
// Ports
//   clk, rst                  clock / synchronous active-high reset
//   fetchValid/Pc/Hit/Target  push side, one prediction per fetched instr
//   fetchReady                queue accepts a push this cycle
//   exValid/Pc/IsBranch/
//   exActualTaken/Target      pop side, resolved outcome from EX
//   updBranch/Taken/Pc/Target predictor update (registered, 1-cycle pulse)
//   redirectValid/redirectPc  one-cycle redirect to the correct next PC
//   flush                     one-cycle squash of younger instructions
//   protocolErr               sticky: pop on empty queue or PC mismatch
//   branchCount, mispredictCount
//                             only present when BRU_PERF_COUNTERS_EN is defined
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchValid,
  input  logic [31:0] fetchPc,
  input  logic        fetchHit,
  input  logic [31:0] fetchTarget,
  output logic        fetchReady,
  input  logic        exValid,
  input  logic [31:0] exPc,
  input  logic        exIsBranch,
  input  logic        exActualTaken,
  input  logic [31:0] exActualTarget,
  output logic        updBranch,
  output logic        updTaken,
  output logic [31:0] updPc,
  output logic [31:0] updTarget,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic        flush,
`ifdef BRU_PERF_COUNTERS_EN
  output logic [31:0] branchCount,
  output logic [31:0] mispredictCount,
`endif
  output logic        protocolErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] flush_cnt_q;

  // Small register-file queue; the head must be visible in the pop cycle,
  // so the read is combinational.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] pred_mem [DEPTH];

  logic        redirect_q, flush_q, err_q;
  logic [31:0] redirect_pc_q;
  logic        upd_branch_q, upd_taken_q;
  logic [31:0] upd_pc_q, upd_target_q;

  logic        full, empty, pop_req, pop, push, mispredict;
  logic [31:0] head_pc, head_pred, act_next;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign fetchReady = (state_q == RUN) && !full;
  assign pop_req    = exValid && (state_q == RUN);
  assign pop        = pop_req && !empty;
  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_pred  = pred_mem[rd_ptr_q];
  assign act_next   = (exIsBranch && exActualTaken) ? exActualTarget : exPc + 32'd4;
  assign mispredict = pop && (head_pred != act_next);
  // A fetch arriving in the mispredict cycle is on the wrong path.
  assign push       = fetchValid && fetchReady && !mispredict;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetchPc;
      pred_mem[wr_ptr_q] <= fetchHit ? fetchTarget : fetchPc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      err_q         <= 1'b0;
      upd_branch_q  <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      redirect_q   <= 1'b0;
      flush_q      <= 1'b0;
      upd_branch_q <= pop && exIsBranch;
      if (pop && exIsBranch) begin
        upd_taken_q  <= exActualTaken;
        upd_pc_q     <= exPc;
        upd_target_q <= exActualTarget;
      end
      // A PC mismatch is flagged but the resolve still goes ahead.
      if ((pop_req && empty) || (pop && (exPc != head_pc))) err_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (mispredict) begin
            state_q       <= FLUSH;
            flush_cnt_q   <= FW'(FLUSH_CYCLES);
            redirect_q    <= 1'b1;
            redirect_pc_q <= act_next;
            flush_q       <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FW'(1)) state_q <= RUN;
          else                        flush_cnt_q <= flush_cnt_q - FW'(1);
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign updBranch     = upd_branch_q;
  assign updTaken      = upd_taken_q;
  assign updPc         = upd_pc_q;
  assign updTarget     = upd_target_q;
  assign redirectValid = redirect_q;
  assign redirectPc    = redirect_pc_q;
  assign flush         = flush_q;
  assign protocolErr   = err_q;

`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_branch_q) branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (redirect_q)   mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branchCount     = branch_cnt_q;
  assign mispredictCount = mispred_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
